// File: rtl/cpu_pkg.sv
// Shared types and decode helpers for the MEM pipeline stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HWRD = 2'd1,
    SZ_WRD  = 2'd2
  } mem_size_t;

  // Byte wins over halfword; anything else (including no size bit) is a word.
  function automatic mem_size_t decode_size(input logic is_byte, input logic is_hwrd);
    mem_size_t sz;
    if (is_byte)      sz = SZ_BYTE;
    else if (is_hwrd) sz = SZ_HWRD;
    else              sz = SZ_WRD;
    return sz;
  endfunction

  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] a);
    logic mis;
    unique case (sz)
      SZ_HWRD: mis = a[0];
      SZ_WRD:  mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] hwrd_sel;

  assign byte_sel = rdata_i[{a_i, 3'b000} +: 8];
  assign hwrd_sel = rdata_i[{a_i[1], 4'b0000} +: 16];

  always_comb begin
    result_o = rdata_i;
    unique case (size_i)
      SZ_BYTE: result_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HWRD: result_o = unsigned_i ? {16'h0, hwrd_sel} : {{16{hwrd_sel[15]}}, hwrd_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: issues aligned loads/stores on the req/ack bus, stalls upstream while
// a transfer is outstanding, and registers the result into the mem_wb stage.
module memory_access
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_mem_writeback,
  input  logic        exec_mem_link,
  input  logic        exec_mem_mem_w,
  input  logic        exec_mem_mem_r,
  input  logic        exec_mem_mem_rdu,
  input  logic        exec_mem_mem_byte,
  input  logic        exec_mem_mem_hwrd,
  input  logic        exec_mem_mem_wrd,
  input  logic [5:0]  exec_mem_rd,
  input  logic [31:0] exec_mem_alu_result,
  input  logic [31:0] exec_mem_mem_wdata,
  output logic        mem_stall,
  output logic [31:0] mem_exec_forward,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_wb_writeback,
  output logic        mem_wb_link,
  output logic [5:0]  mem_wb_rd,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_misalign,
  output logic        mem_wb_buserr
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  mem_state_t state_q, state_d;

  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             hold_wb_q, hold_wb_d, hold_link_q, hold_link_d;
  logic             hold_load_q, hold_load_d, hold_rdu_q, hold_rdu_d;
  logic [5:0]       hold_rd_q, hold_rd_d;
  logic [31:0]      hold_alu_q, hold_alu_d;
  mem_size_t        hold_size_q, hold_size_d;

  logic             wb_wb_q, wb_wb_d, wb_link_q, wb_link_d;
  logic [5:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_res_q, wb_res_d;
  logic             wb_mis_q, wb_mis_d, wb_err_q, wb_err_d;

  mem_size_t   size_c;
  logic [1:0]  a_c;
  logic        mem_op_c, misalign_c, aligned_op_c, is_store_c, timeout_hit_c;
  logic [3:0]  st_strb_c;
  logic [31:0] st_wdata_c, ext_c;
  logic        unused_wrd;

  // Word size is the fallback when neither byte nor halfword is set.
  assign unused_wrd = exec_mem_mem_wrd;

  assign size_c        = decode_size(exec_mem_mem_byte, exec_mem_mem_hwrd);
  assign a_c           = exec_mem_alu_result[1:0];
  assign mem_op_c      = exec_mem_mem_r | exec_mem_mem_w;
  assign is_store_c    = exec_mem_mem_w;
  assign misalign_c    = mem_op_c & is_misaligned(size_c, a_c);
  assign aligned_op_c  = mem_op_c & ~misalign_c;
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TMO_LAST));

  always_comb begin
    st_strb_c  = 4'hF;
    st_wdata_c = exec_mem_mem_wdata;
    unique case (size_c)
      SZ_BYTE: begin
        st_strb_c  = 4'(4'b0001 << a_c);
        st_wdata_c = {4{exec_mem_mem_wdata[7:0]}};
      end
      SZ_HWRD: begin
        st_strb_c  = 4'(4'b0011 << a_c);
        st_wdata_c = {2{exec_mem_mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .rdata_i    (dmem_rdata),
    .a_i        (hold_alu_q[1:0]),
    .size_i     (hold_size_q),
    .unsigned_i (hold_rdu_q),
    .result_o   (ext_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (aligned_op_c) state_d = BUSY;
      BUSY:    if (dmem_ack || timeout_hit_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; mem_wb defaults to a bubble every cycle.
  always_comb begin
    mem_stall   = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    hold_wb_d   = hold_wb_q;
    hold_link_d = hold_link_q;
    hold_load_d = hold_load_q;
    hold_rdu_d  = hold_rdu_q;
    hold_rd_d   = hold_rd_q;
    hold_alu_d  = hold_alu_q;
    hold_size_d = hold_size_q;
    wb_wb_d     = 1'b0;
    wb_link_d   = 1'b0;
    wb_rd_d     = '0;
    wb_res_d    = '0;
    wb_mis_d    = 1'b0;
    wb_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aligned_op_c) begin
          mem_stall   = 1'b1;
          req_d       = 1'b1;
          we_d        = is_store_c;
          addr_d      = {exec_mem_alu_result[31:2], 2'b00};
          strb_d      = is_store_c ? st_strb_c : 4'h0;
          wdata_d     = is_store_c ? st_wdata_c : 32'h0;
          cnt_d       = '0;
          err_d       = 1'b0;
          hold_wb_d   = exec_mem_writeback;
          hold_link_d = exec_mem_link;
          hold_load_d = ~is_store_c;
          hold_rdu_d  = exec_mem_mem_rdu;
          hold_rd_d   = exec_mem_rd;
          hold_alu_d  = exec_mem_alu_result;
          hold_size_d = size_c;
        end else begin
          wb_wb_d   = exec_mem_writeback & ~misalign_c;
          wb_link_d = exec_mem_link;
          wb_rd_d   = exec_mem_rd;
          wb_res_d  = exec_mem_alu_result;
          wb_mis_d  = misalign_c;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          rdata_d = ext_c;
          req_d   = 1'b0;
        end else if (timeout_hit_c) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        wb_wb_d   = hold_wb_q & ~err_q;
        wb_link_d = hold_link_q;
        wb_rd_d   = hold_rd_q;
        wb_res_d  = hold_load_q ? rdata_q : hold_alu_q;
        wb_err_d  = err_q;
        err_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      hold_wb_q   <= 1'b0;
      hold_link_q <= 1'b0;
      hold_load_q <= 1'b0;
      hold_rdu_q  <= 1'b0;
      hold_rd_q   <= '0;
      hold_alu_q  <= '0;
      hold_size_q <= SZ_WRD;
      wb_wb_q     <= 1'b0;
      wb_link_q   <= 1'b0;
      wb_rd_q     <= '0;
      wb_res_q    <= '0;
      wb_mis_q    <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      hold_wb_q   <= hold_wb_d;
      hold_link_q <= hold_link_d;
      hold_load_q <= hold_load_d;
      hold_rdu_q  <= hold_rdu_d;
      hold_rd_q   <= hold_rd_d;
      hold_alu_q  <= hold_alu_d;
      hold_size_q <= hold_size_d;
      wb_wb_q     <= wb_wb_d;
      wb_link_q   <= wb_link_d;
      wb_rd_q     <= wb_rd_d;
      wb_res_q    <= wb_res_d;
      wb_mis_q    <= wb_mis_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign mem_exec_forward = exec_mem_alu_result;
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wstrb       = strb_q;
  assign dmem_wdata       = wdata_q;
  assign mem_wb_writeback = wb_wb_q;
  assign mem_wb_link      = wb_link_q;
  assign mem_wb_rd        = wb_rd_q;
  assign mem_wb_result    = wb_res_q;
  assign mem_wb_misalign  = wb_mis_q;
  assign mem_wb_buserr    = wb_err_q;

endmodule

// File: tb/tb_memory_access.sv
// Table-driven bench for memory_access with an expected-result queue.
module tb_memory_access;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wb, ex_link, ex_mw, ex_mr, ex_rdu, ex_byte, ex_hwrd, ex_wrd;
  logic [5:0]  ex_rd;
  logic [31:0] ex_alu, ex_wdata;
  logic        mem_stall;
  logic [31:0] fwd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_wb, wb_link, wb_mis, wb_err;
  logic [5:0]  wb_rd;
  logic [31:0] wb_res;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .exec_mem_writeback(ex_wb), .exec_mem_link(ex_link),
    .exec_mem_mem_w(ex_mw), .exec_mem_mem_r(ex_mr), .exec_mem_mem_rdu(ex_rdu),
    .exec_mem_mem_byte(ex_byte), .exec_mem_mem_hwrd(ex_hwrd), .exec_mem_mem_wrd(ex_wrd),
    .exec_mem_rd(ex_rd), .exec_mem_alu_result(ex_alu), .exec_mem_mem_wdata(ex_wdata),
    .mem_stall(mem_stall), .mem_exec_forward(fwd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_wb_writeback(wb_wb), .mem_wb_link(wb_link), .mem_wb_rd(wb_rd),
    .mem_wb_result(wb_res), .mem_wb_misalign(wb_mis), .mem_wb_buserr(wb_err)
  );

  typedef struct {
    logic [7:0]  ctl;     // {wb, link, mem_w, mem_r, rdu, byte, hwrd, wrd}
    logic [5:0]  rd;
    logic [31:0] alu, wdata, rdata;
    int          ack_at;  // BUSY cycle (1-based) carrying ack; 0 = never
    int          e_stall;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic        e_we;
    logic [31:0] e_wdata, e_res;
    logic [2:0]  e_flags; // {writeback, misalign, buserr}
  } vec_t;

  typedef struct {
    logic        wb, link, mis, err, chk_res;
    logic [5:0]  rd;
    logic [31:0] res;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q_exp[$];
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] ctl, input logic [5:0] rd, input logic [31:0] alu,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                              input int e_stall, input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic e_we, input logic [31:0] e_wdata, input logic [31:0] e_res,
                              input logic [2:0] e_flags);
    vec_t v;
    v.ctl = ctl; v.rd = rd; v.alu = alu; v.wdata = wdata; v.rdata = rdata;
    v.ack_at = ack_at; v.e_stall = e_stall; v.e_addr = e_addr; v.e_strb = e_strb;
    v.e_we = e_we; v.e_wdata = e_wdata; v.e_res = e_res; v.e_flags = e_flags;
    return v;
  endfunction

  task automatic drive_nop();
    {ex_wb, ex_link, ex_mw, ex_mr, ex_rdu, ex_byte, ex_hwrd, ex_wrd} = 8'h00;
    ex_rd = '0; ex_alu = '0; ex_wdata = '0;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    exp_t e;
    int   stalls = 0;
    int   busy   = 0;
    bit   fields_ok = 1'b1;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    {ex_wb, ex_link, ex_mw, ex_mr, ex_rdu, ex_byte, ex_hwrd, ex_wrd} = v.ctl;
    ex_rd = v.rd; ex_alu = v.alu; ex_wdata = v.wdata;
    dmem_rdata = v.rdata; dmem_ack = 1'b0;
    e.wb = v.e_flags[2]; e.mis = v.e_flags[1]; e.err = v.e_flags[0];
    e.link = v.ctl[6]; e.rd = v.rd; e.res = v.e_res;
    e.chk_res = !(v.e_flags[1] || v.e_flags[0]);
    q_exp.push_back(e);
    #1;
    check({tag, "_forward"}, fwd, v.alu);
    for (int c = 0; c < 40; c++) begin
      if (!mem_stall) break;
      stalls++;
      if (dmem_req) begin
        busy++;
        if (dmem_addr !== v.e_addr || dmem_we !== v.e_we || dmem_wstrb !== v.e_strb ||
            (v.e_we && dmem_wdata !== v.e_wdata)) fields_ok = 1'b0;
        dmem_ack = (v.ack_at != 0) && (busy == v.ack_at);
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    dmem_ack = 1'b0;
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(v.e_stall));
    if (v.e_stall > 1) check({tag, "_dmem_fields"}, 32'(fields_ok), 32'd1);
    @(negedge clk);
    drive_nop();
    if (q_exp.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_queue actual=empty required=entry", tag);
    end else begin
      e = q_exp.pop_front();
      check({tag, "_wb_flags"}, {29'h0, wb_wb, wb_mis, wb_err}, {29'h0, e.wb, e.mis, e.err});
      check({tag, "_rd_link"}, {25'h0, wb_link, wb_rd}, {25'h0, e.link, e.rd});
      if (e.chk_res) check({tag, "_result"}, wb_res, e.res);
      check({tag, "_req_low"}, 32'(dmem_req), 32'd0);
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, {30'h0, wb_mis, wb_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive_nop();
    repeat (2) @(negedge clk);
    #1;
    check("reset_dmem", {dmem_req, dmem_we, dmem_wstrb, 26'h0} | dmem_addr | dmem_wdata, 32'd0);
    check("reset_mem_wb", {wb_wb, wb_link, wb_mis, wb_err, wb_rd, 22'h0} | wb_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = mk(8'b1001_0001, 6'd5,  32'h100,  32'h0,        32'hDEADBEEF, 1, 2, 32'h100, 4'h0,    1'b0, 32'h0,        32'hDEADBEEF, 3'b100);
    vecs[1]  = mk(8'b1001_0100, 6'd6,  32'h103,  32'h0,        32'h80000000, 1, 2, 32'h100, 4'h0,    1'b0, 32'h0,        32'hFFFFFF80, 3'b100);
    vecs[2]  = mk(8'b1001_1100, 6'd6,  32'h103,  32'h0,        32'h80000000, 1, 2, 32'h100, 4'h0,    1'b0, 32'h0,        32'h00000080, 3'b100);
    vecs[3]  = mk(8'b0010_0010, 6'd0,  32'h102,  32'h00001234, 32'h0,        3, 4, 32'h100, 4'b1100, 1'b1, 32'h12341234, 32'h102,      3'b000);
    vecs[4]  = mk(8'b1001_0001, 6'd8,  32'h101,  32'h0,        32'h0,        0, 0, 32'h0,   4'h0,    1'b0, 32'h0,        32'h0,        3'b010);
    vecs[5]  = mk(8'b1001_0001, 6'd9,  32'h200,  32'h0,        32'h0,        0, 5, 32'h200, 4'h0,    1'b0, 32'h0,        32'h0,        3'b001);
    vecs[6]  = mk(8'b1000_0000, 6'd7,  32'h55,   32'h0,        32'h0,        0, 0, 32'h0,   4'h0,    1'b0, 32'h0,        32'h55,       3'b100);
    vecs[7]  = mk(8'b1100_0000, 6'd31, 32'h1004, 32'h0,        32'h0,        0, 0, 32'h0,   4'h0,    1'b0, 32'h0,        32'h1004,     3'b100);
    vecs[8]  = mk(8'b0010_0100, 6'd0,  32'h201,  32'h000000AB, 32'h0,        2, 3, 32'h200, 4'b0010, 1'b1, 32'hABABABAB, 32'h201,      3'b000);
    vecs[9]  = mk(8'b1001_0010, 6'd10, 32'h302,  32'h0,        32'h80017FFF, 2, 3, 32'h300, 4'h0,    1'b0, 32'h0,        32'hFFFF8001, 3'b100);
    vecs[10] = mk(8'b1001_1010, 6'd10, 32'h302,  32'h0,        32'h80017FFF, 2, 3, 32'h300, 4'h0,    1'b0, 32'h0,        32'h00008001, 3'b100);
    vecs[11] = mk(8'b0010_0001, 6'd0,  32'h400,  32'h12345678, 32'h0,        1, 2, 32'h400, 4'hF,    1'b1, 32'h12345678, 32'h400,      3'b000);
    vecs[12] = mk(8'b0010_0010, 6'd0,  32'h103,  32'h00001234, 32'h0,        0, 0, 32'h0,   4'h0,    1'b0, 32'h0,        32'h0,        3'b010);
    vecs[13] = mk(8'b0011_0100, 6'd0,  32'h102,  32'h0000005A, 32'hFFFFFFFF, 1, 2, 32'h100, 4'b0100, 1'b1, 32'h5A5A5A5A, 32'h102,      3'b000);
    vecs[14] = mk(8'b1001_0000, 6'd11, 32'h10,   32'h0,        32'hCAFEF00D, 1, 2, 32'h10,  4'h0,    1'b0, 32'h0,        32'hCAFEF00D, 3'b100);
    vecs[15] = mk(8'b1001_0100, 6'd12, 32'h101,  32'h0,        32'h00007F00, 1, 2, 32'h100, 4'h0,    1'b0, 32'h0,        32'h0000007F, 3'b100);

    foreach (vecs[i]) run_op(vecs[i], i);

    // Stray ack while idle must not start anything.
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("stray_ack_req", {31'h0, dmem_req}, 32'd0);
    check("stray_ack_stall", {31'h0, mem_stall}, 32'd0);
    run_op(vecs[0], 100);

    // Reset in the middle of an outstanding load.
    @(negedge clk);
    {ex_wb, ex_link, ex_mw, ex_mr, ex_rdu, ex_byte, ex_hwrd, ex_wrd} = 8'b1001_0001;
    ex_rd = 6'd3; ex_alu = 32'h500; dmem_rdata = 32'h11111111;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy_req_before", {31'h0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_busy_req_after", {31'h0, dmem_req}, 32'd0);
    check("rst_busy_mem_wb", {wb_wb, wb_link, wb_mis, wb_err, wb_rd, 22'h0} | wb_res, 32'd0);
    rst = 1'b0;
    drive_nop();
    repeat (3) @(negedge clk);
    #1;
    check("rst_no_completion", {29'h0, wb_wb, wb_err, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline MEM stage. Sits on the far side of the exec_mem_* interface and consumes what execute produces: control, ALU result, store data and rd.
- Issues load/store transactions to data memory over a req/ack bus.
- Aligns and extends load data, builds store byte strobes.
- Stalls the upstream pipeline while a bus transaction is outstanding.
- Registers results into the mem_wb_* stage and drives the Mem-Ex forwarding path.

Parameters:
- TIMEOUT, 16, max BUSY cycles without dmem_ack before the access is aborted as a bus error; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- exec_mem_writeback  in  1  op writes rd.
- exec_mem_link  in  1  link op; passed through.
- exec_mem_mem_w  in  1  store.
- exec_mem_mem_r  in  1  load.
- exec_mem_mem_rdu  in  1  unsigned load.
- exec_mem_mem_byte  in  1  byte size.
- exec_mem_mem_hwrd  in  1  halfword size.
- exec_mem_mem_wrd  in  1  word size.
- exec_mem_rd  in  6  destination register.
- exec_mem_alu_result  in  32  ALU result, also the effective address.
- exec_mem_mem_wdata  in  32  store data, right-justified.
- mem_stall  out  1  hold the exec_mem and earlier stages this cycle.
- mem_exec_forward  out  32  combinational exec_mem_alu_result, for Mem-Ex forwarding.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address; bits [1:0] are always 0.
- dmem_wstrb  out  4  byte strobes.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  transfer complete.
- dmem_rdata  in  32  read word.
- mem_wb_writeback  out  1  registered.
- mem_wb_link  out  1  registered.
- mem_wb_rd  out  6  registered.
- mem_wb_result  out  32  ALU result or formatted load data.
- mem_wb_misalign  out  1  misaligned access flag, one-cycle pulse.
- mem_wb_buserr  out  1  bus timeout flag, one-cycle pulse.

Behaviour:
- Reset: state IDLE; timeout counter 0; all dmem_* outputs 0; all mem_wb_* outputs 0.
  - A reset during BUSY drops dmem_req on the next edge. No completion is reported.
- Memory op: mem_r or mem_w set. Access size:
  - byte if mem_byte is set.
  - otherwise halfword if mem_hwrd is set.
  - otherwise word (this covers mem_wrd set and no size bit set).
  - a = exec_mem_alu_result[1:0].
- Misaligned: halfword with a[0]=1, or word with a != 0.
  - No bus request and no stall.
  - Next edge: mem_wb_misalign=1, mem_wb_writeback=0.
- Non-memory op in IDLE:
  - mem_stall=0.
  - Next edge loads mem_wb_* from exec_mem_*; mem_wb_result = alu_result.
  - Latency 1.
- FSM for an aligned memory op:
  - IDLE:
    - mem_stall=1 combinationally.
    - Edge: dmem_req<=1; dmem_addr, dmem_we, dmem_wstrb, dmem_wdata registered; counter cleared; mem_wb_* loaded as a bubble (writeback, misalign and buserr all 0); go to BUSY.
  - BUSY:
    - mem_stall=1; dmem_* held stable; mem_wb bubble each edge.
    - On dmem_ack=1: capture the formatted load data into rdata_q, dmem_req<=0, go to DONE.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1: dmem_req<=0, set err_q, go to DONE.
    - Else counter+1.
  - DONE:
    - mem_stall=0, so upstream advances at this edge.
    - Edge loads mem_wb from the held exec_mem op. mem_wb_result is rdata_q for loads and alu_result for stores.
    - If err_q: mem_wb_buserr=1 and mem_wb_writeback=0. Clear err_q.
    - Go to IDLE.
- Minimum load latency: op visible at cycle N, ack at N+1, mem_wb valid after the N+2 edge. Two stall cycles.
- Store formatting:
  - byte: wstrb = 1<<a; wdata = {4{wdata[7:0]}}.
  - halfword: wstrb = 3<<a; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'hF; wdata passed as-is.
  - Loads drive wstrb=0 and we=0.
- Load formatting:
  - byte: rdata[8a+:8].
  - halfword: rdata[16a[1]+:16].
  - Sign-extend to 32 bits unless mem_rdu is set.
- dmem_ack outside BUSY is ignored.
- mem_r and mem_w both set is treated as a store.

Decomposition:
- cpu_pkg gets:
  - mem_state_t enum {IDLE, BUSY, DONE}.
  - mem_size_t enum {SZ_BYTE, SZ_HWRD, SZ_WRD}.
  - a size-decode function.
  - a misalignment-check function.
- One combinational sub-module, load_extend:
  - inputs: rdata, a, size, unsigned.
  - output: 32-bit extended result.

Test Plan:
- Word load, addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF:
  - dmem_addr=0x100, wstrb=0.
  - mem_stall high exactly 2 cycles.
  - mem_wb_result=0xDEADBEEF with writeback=1.
- Signed byte load, addr 0x103, rdata 0x80000000 -> mem_wb_result=0xFFFFFF80.
- The same byte load with mem_rdu=1 -> mem_wb_result=0x00000080.
- Halfword store, addr 0x102, wdata 0x00001234, ack delayed 3 cycles:
  - dmem_we=1, wstrb=4'b1100, dmem_wdata=0x12341234.
  - All dmem_* stable until ack; mem_stall high for 4 cycles.
- Word load at 0x101:
  - No dmem_req and no stall.
  - mem_wb_misalign=1 for one cycle, writeback=0.
- TIMEOUT=4, load with no ack:
  - req drops after 4 BUSY cycles.
  - mem_wb_buserr=1 for one cycle, writeback=0.
  - A following ALU op with alu_result 0x55 passes through with 1-cycle latency; assert rst during a second BUSY and check req=0 and all mem_wb_* = 0 the next cycle.
